gamma_wta_sched: RTL and testbench
==================================

// Module: gamma_wta_sched
// PURPOSE
//  Gamma-cycle sequencer and first-spike arbiter for temporal columns. Owns the free-running
//  gamma counter, marks gamma boundaries, and picks one winner per gamma cycle among NUM_REQ
//  temporal select/spike lines: the earliest spike wins, and priority breaks ties.
//  Each cycle's result (winner index and spike time) is handed downstream on a valid/ready
//  interface, where it drives the binary->temporal select muxes.
// PARAMETERS
//  GAMMA_CYCLE_WIDTH  16                          aclk cycles per gamma cycle (>=2)
//  NUM_REQ            16                          number of temporal requesters (>=2)
//  TIME_W             $clog2(GAMMA_CYCLE_WIDTH)   spike-time width
//  IDX_W              $clog2(NUM_REQ)             winner-index width
// PORTS
//  aclk         in   1        clock
//  grst         in   1        reset; synchronous, active-high
//  enable       in   1        run gamma cycles
//  req          in   NUM_REQ  temporal spike lines, sampled each aclk
//  gamma_start  out  1        high in the first aclk of each gamma cycle
//  gamma_count  out  TIME_W   position inside the current gamma cycle
//  out_valid    out  1        a result is held
//  out_ready    in   1        downstream accepts the result
//  win_idx      out  IDX_W    winning requester
//  win_time     out  TIME_W   gamma_count value when the winner spiked
//  win_none     out  1        no requester spiked in that gamma cycle
//  overrun      out  1        1-cycle pulse: a result was dropped
// BEHAVIOUR
//  Reset: every output is 0, state=IDLE, captured=0, rotating pointer=0.
//  FSM IDLE->RUN: when enable=1, sampled in IDLE. Counting starts at 0 on the next cycle.
//  FSM RUN->IDLE: after the cycle with count==G-1 if enable=0.
//   - A gamma cycle in progress always completes, even if enable drops mid-cycle.
//  In RUN:
//   - gamma_count increments each cycle and wraps G-1 -> 0.
//   - gamma_start = (state==RUN && count==0).
//   - In IDLE, gamma_count is held at 0.
//  Capture:
//   - Applies in the first RUN cycle with |req && !captured.
//   - Stores time=gamma_count and idx=arbiter pick, then sets captured=1.
//   - Later spikes in the same gamma cycle are ignored.
//   - A spike at count==G-1 is captured.
//  Result generation:
//   - In the cycle with count==G-1, the result is formed from the capture values, including
//     a same-cycle capture.
//   - If nothing was captured: win_none=1, win_idx=0, win_time=0.
//   - captured is cleared in that same cycle.
//  Output register update: on the edge after count==G-1.
//   - If !out_valid || out_ready: load the result; out_valid=1 from the next cycle, which
//     coincides with gamma_start.
//   - Otherwise: keep the held result and pulse overrun=1 for one cycle.
//  Handshake:
//   - out_valid && out_ready with no new result -> out_valid=0 next cycle.
//   - win_* outputs are stable while out_valid && !out_ready.
//   - A new result arriving in the same cycle as out_ready is loaded, with no overrun.
//  Reset mid-gamma: capture and the held result are discarded, and the block returns to IDLE.
// CONFIGURATION
//  Macro ROUND_ROBIN_TIE_EN:
//   - Defined: ties at the same cycle go to the first set req at index >= ptr, wrapping.
//     ptr <= win_idx+1 (mod NUM_REQ) on every capture.
//   - Undefined: the lowest set index wins; no pointer state exists.
// STRUCTURE
//  Package gamma_pkg:
//   - typedef enum logic {IDLE, RUN} gsched_state_t
//   - localparams for TIME_W and IDX_W
//   - typedef struct {idx, time, none} gamma_result_t
//  Sub-module gamma_prio_arb: combinational NUM_REQ-way priority picker with an optional
//  rotating base input.
// TESTING (G=16, NUM_REQ=4)
//  - Single spike: enable; req[2] pulsed at count 5 -> after count 15: out_valid=1,
//    win_idx=2, win_time=5, win_none=0, same cycle as gamma_start.
//  - Tie: req=4'b1010 at count 3.
//    - Fixed priority: win_idx=1.
//    - ROUND_ROBIN_TIE_EN, ptr=2: win_idx=3, then ptr=0.
//  - Earliest wins: req[0] at count 9, req[3] at count 4 -> win_idx=3, win_time=4; the later
//    spike is ignored.
//  - Empty and edge: no req for a whole gamma -> win_none=1, win_idx=0, win_time=0.
//    req[1] only at count 15 -> win_time=15.
//  - Backpressure: hold out_ready=0 across two gamma ends -> first result held, overrun=1 for
//    exactly 1 cycle. out_ready=1 at the next boundary -> new result loaded, no overrun.
//  - Control: drop enable at count 7 -> gamma completes, result emitted, gamma_count stays 0
//    afterwards. grst at count 10 -> all outputs 0, IDLE.

Source files
------------

// File: rtl/gamma_pkg.sv
// Shared types for the gamma-cycle winner-take-all scheduler.
// ROUND_ROBIN_TIE_EN selects rotating tie-break in gamma_wta_sched.
package gamma_pkg;

    localparam int GAMMA_CYCLE_DEF = 16;
    localparam int NUM_REQ_DEF     = 16;
    localparam int GAMMA_TIME_W    = $clog2(GAMMA_CYCLE_DEF);
    localparam int GAMMA_IDX_W     = $clog2(NUM_REQ_DEF);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } gsched_state_t;

    // Result bundle at the default geometry.
    typedef struct packed {
        logic [GAMMA_IDX_W-1:0]  idx;
        logic [GAMMA_TIME_W-1:0] spk_time;
        logic                    none;
    } gamma_result_t;

endpackage

// File: rtl/gamma_prio_arb.sv
// Combinational priority picker: first set request at or after base,
// wrapping past NUM_REQ-1 back to 0.
module gamma_prio_arb #(
    parameter int NUM_REQ = 16,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   base,
    output logic               any,
    output logic [IDX_W-1:0]   idx
);

    int               j;
    logic [IDX_W-1:0] jj;

    always_comb begin
        any = 1'b0;
        idx = '0;
        j   = 0;
        jj  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j  = (int'(base) + k) % NUM_REQ;
            jj = IDX_W'(j);
            if (!any && req[jj]) begin
                any = 1'b1;
                idx = jj;
            end
        end
    end

endmodule

// File: rtl/gamma_wta_sched.sv
// Gamma-cycle sequencer with first-spike winner-take-all arbitration.
// Define ROUND_ROBIN_TIE_EN for rotating tie-break instead of lowest index.
module gamma_wta_sched
    import gamma_pkg::*;
#(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int NUM_REQ           = 16,
    parameter int TIME_W            = $clog2(GAMMA_CYCLE_WIDTH),
    parameter int IDX_W             = $clog2(NUM_REQ)
) (
    input  logic               aclk,
    input  logic               grst,
    input  logic               enable,
    input  logic [NUM_REQ-1:0] req,
    output logic               gamma_start,
    output logic [TIME_W-1:0]  gamma_count,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IDX_W-1:0]   win_idx,
    output logic [TIME_W-1:0]  win_time,
    output logic               win_none,
    output logic               overrun
);

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [TIME_W-1:0] spk_time;
        logic              none;
    } res_t;

    localparam logic [TIME_W-1:0] LAST = TIME_W'(GAMMA_CYCLE_WIDTH - 1);
    localparam logic [IDX_W-1:0]  TOP  = IDX_W'(NUM_REQ - 1);

    gsched_state_t     state_q, state_d;
    logic [TIME_W-1:0] cnt_q, cnt_d;
    logic              captured_q, captured_d;
    logic [IDX_W-1:0]  cap_idx_q, cap_idx_d;
    logic [TIME_W-1:0] cap_time_q, cap_time_d;
    res_t              res_q, res_d, res_new;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;

    logic              run, last, cap_now, any;
    logic [IDX_W-1:0]  base, pick;

`ifdef ROUND_ROBIN_TIE_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    assign base  = ptr_q;
    assign ptr_d = !cap_now ? ptr_q
                 : (pick == TOP) ? '0 : pick + 1'b1;
`else
    assign base = '0;
`endif

    gamma_prio_arb #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req  (req),
        .base (base),
        .any  (any),
        .idx  (pick)
    );

    assign run  = (state_q == RUN);
    assign last = run && (cnt_q == LAST);

    always_ff @(posedge aclk) begin
        if (grst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            captured_q <= 1'b0;
            cap_idx_q  <= '0;
            cap_time_q <= '0;
            res_q      <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef ROUND_ROBIN_TIE_EN
            ptr_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            captured_q <= captured_d;
            cap_idx_q  <= cap_idx_d;
            cap_time_q <= cap_time_d;
            res_q      <= res_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
`ifdef ROUND_ROBIN_TIE_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    // A running gamma cycle always finishes before returning to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (enable) state_d = RUN;
            RUN:  if (last && !enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gamma_start = run && (cnt_q == '0);
        gamma_count = cnt_q;
        out_valid   = valid_q;
        win_idx     = res_q.idx;
        win_time    = res_q.spk_time;
        win_none    = res_q.none;
        overrun     = overrun_q;
    end

    always_comb begin
        cnt_d = '0;
        if (run && !last) cnt_d = cnt_q + 1'b1;

        cap_now    = run && any && !captured_q;
        captured_d = captured_q;
        cap_idx_d  = cap_idx_q;
        cap_time_d = cap_time_q;
        if (cap_now) begin
            captured_d = 1'b1;
            cap_idx_d  = pick;
            cap_time_d = cnt_q;
        end

        res_new = '{idx: '0, spk_time: '0, none: 1'b1};
        if (cap_now) begin
            res_new = '{idx: pick, spk_time: cnt_q, none: 1'b0};
        end else if (captured_q) begin
            res_new = '{idx: cap_idx_q, spk_time: cap_time_q, none: 1'b0};
        end

        res_d     = res_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        // A full output slot that is not being drained drops the new result.
        if (last) begin
            captured_d = 1'b0;
            if (!valid_q || out_ready) begin
                res_d   = res_new;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_gamma_wta_sched.sv
// Self-checking bench for gamma_wta_sched (G=16, NUM_REQ=4) against a
// per-gamma earliest-spike reference model.
module tb_gamma_wta_sched;

    localparam int G  = 16;
    localparam int NR = 4;
    localparam int TW = 4;
    localparam int IW = 2;

    logic          aclk = 1'b0;
    logic          grst, enable, out_ready;
    logic [NR-1:0] req;
    logic          gamma_start, out_valid, win_none, overrun;
    logic [TW-1:0] gamma_count, win_time;
    logic [IW-1:0] win_idx;

    int n_cmp = 0;
    int n_bad = 0;

    logic [NR-1:0] pat [G];
    int            m_ptr = 0;
    logic [IW-1:0] e_idx;
    logic [TW-1:0] e_time;
    logic          e_none;
    logic [9:0]    got, exp_v;

    always #5 aclk = ~aclk;

    gamma_wta_sched #(
        .GAMMA_CYCLE_WIDTH (G),
        .NUM_REQ           (NR)
    ) dut (
        .aclk        (aclk),
        .grst        (grst),
        .enable      (enable),
        .req         (req),
        .gamma_start (gamma_start),
        .gamma_count (gamma_count),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .win_idx     (win_idx),
        .win_time    (win_time),
        .win_none    (win_none),
        .overrun     (overrun)
    );

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_pat();
        for (int c = 0; c < G; c++) pat[c] = '0;
    endtask

    // Earliest spike time wins; ties resolved by index priority.
    task automatic model_gamma();
        logic done, hit;
        int   j;
        done   = 1'b0;
        e_none = 1'b1;
        e_idx  = '0;
        e_time = '0;
        for (int c = 0; c < G; c++) begin
            if (!done && pat[c] != '0) begin
                done   = 1'b1;
                e_none = 1'b0;
                e_time = TW'(c);
                hit    = 1'b0;
`ifdef ROUND_ROBIN_TIE_EN
                for (int k = 0; k < NR; k++) begin
                    j = (m_ptr + k) % NR;
                    if (!hit && pat[c][j]) begin
                        hit   = 1'b1;
                        e_idx = IW'(j);
                    end
                end
                m_ptr = (int'(e_idx) + 1) % NR;
`else
                for (j = NR - 1; j >= 0; j--) begin
                    if (pat[c][j]) e_idx = IW'(j);
                end
`endif
            end
        end
    endtask

    // rmode: 0 ready always, 1 ready only at count 0,
    // 2 ready only at count G-1, 3 never ready.
    task automatic run_gamma(input int rmode, input int drop_at,
                             output logic ov1);
        ov1 = 1'b0;
        for (int c = 0; c < G; c++) begin
            n_cmp++;
            if ({gamma_start, gamma_count} !== {c == 0, TW'(c)}) begin
                n_bad++;
                $display("FAIL count pos %0d: got start=%0b cnt=%0d",
                         c, gamma_start, gamma_count);
            end
            if (c == 1) ov1 = overrun;
            req = pat[c];
            out_ready = (rmode == 0) || (rmode == 1 && c == 0)
                     || (rmode == 2 && c == G - 1);
            if (c == drop_at) enable = 1'b0;
            step();
        end
        req = '0;
    endtask

    task automatic test_reset();
        grst = 1'b1; enable = 1'b0; out_ready = 1'b0; req = '0;
        step();
        step();
        got = {gamma_start, out_valid, overrun, win_none, win_idx, win_time};
        n_cmp++;
        if (got !== 10'd0 || gamma_count !== '0) begin
            n_bad++;
            $display("FAIL reset: got %b cnt=%0d want 0", got, gamma_count);
        end
        grst = 1'b0;
        step();
        step();
        n_cmp++;
        if ({gamma_start, gamma_count} !== 5'd0) begin
            n_bad++;
            $display("FAIL idle_hold: got %b want 0",
                     {gamma_start, gamma_count});
        end
        enable = 1'b1;
        step();
        n_cmp++;
        if ({gamma_start, gamma_count} !== {1'b1, 4'd0}) begin
            n_bad++;
            $display("FAIL first_run: got %b want 10000",
                     {gamma_start, gamma_count});
        end
    endtask

    task automatic test_patterns();
        logic  ov;
        string nm [5] = '{"single", "tie", "earliest", "empty", "edge15"};
        for (int t = 0; t < 5; t++) begin
            clear_pat();
            case (t)
                0: pat[5] = 4'b0100;
                1: pat[3] = 4'b1010;
                2: begin pat[9] = 4'b0001; pat[4] = 4'b1000; end
                3: ;
                default: pat[15] = 4'b0010;
            endcase
            run_gamma(0, -1, ov);
            model_gamma();
            got   = {gamma_start, out_valid, overrun, win_none, win_idx, win_time};
            exp_v = {1'b1, 1'b1, 1'b0, e_none, e_idx, e_time};
            n_cmp++;
            if (got !== exp_v) begin
                n_bad++;
                $display("FAIL %s: got %b want %b", nm[t], got, exp_v);
            end
        end
    endtask

    task automatic test_random();
        logic ov;
        for (int g = 0; g < 24; g++) begin
            for (int c = 0; c < G; c++) begin
                pat[c] = ($urandom_range(0, 5) == 0)
                       ? NR'($urandom_range(1, 15)) : '0;
            end
            run_gamma(0, -1, ov);
            model_gamma();
            got   = {gamma_start, out_valid, overrun, win_none, win_idx, win_time};
            exp_v = {1'b1, 1'b1, 1'b0, e_none, e_idx, e_time};
            n_cmp++;
            if (got !== exp_v) begin
                n_bad++;
                $display("FAIL random g%0d: got %b want %b", g, got, exp_v);
            end
        end
    endtask

    task automatic test_backpressure();
        logic       ov;
        logic [6:0] a_res;
        clear_pat();
        pat[6] = 4'b0001;
        run_gamma(1, -1, ov);
        model_gamma();
        a_res = {e_none, e_idx, e_time};
        got   = {gamma_start, out_valid, overrun, win_none, win_idx, win_time};
        exp_v = {3'b110, a_res};
        n_cmp++;
        if (got !== exp_v) begin
            n_bad++;
            $display("FAIL bp_first: got %b want %b", got, exp_v);
        end
        clear_pat();
        pat[2] = 4'b0100;
        run_gamma(3, -1, ov);
        model_gamma();
        got   = {gamma_start, out_valid, overrun, win_none, win_idx, win_time};
        exp_v = {3'b111, a_res};
        n_cmp++;
        if (got !== exp_v) begin
            n_bad++;
            $display("FAIL bp_overrun: got %b want %b", got, exp_v);
        end
        clear_pat();
        pat[11] = 4'b1000;
        run_gamma(2, -1, ov);
        n_cmp++;
        if (ov !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_pulse_len: got overrun=%b want 0", ov);
        end
        model_gamma();
        got   = {gamma_start, out_valid, overrun, win_none, win_idx, win_time};
        exp_v = {3'b110, e_none, e_idx, e_time};
        n_cmp++;
        if (got !== exp_v) begin
            n_bad++;
            $display("FAIL bp_reload: got %b want %b", got, exp_v);
        end
    endtask

    task automatic test_control();
        logic ov;
        clear_pat();
        pat[8] = 4'b0110;
        run_gamma(0, 7, ov);
        model_gamma();
        got   = {gamma_start, out_valid, overrun, win_none, win_idx, win_time};
        exp_v = {3'b010, e_none, e_idx, e_time};
        n_cmp++;
        if (got !== exp_v) begin
            n_bad++;
            $display("FAIL drop_enable: got %b want %b", got, exp_v);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if ({gamma_start, gamma_count} !== 5'd0) begin
                n_bad++;
                $display("FAIL idle_after_drop: got %b want 0",
                         {gamma_start, gamma_count});
            end
        end
        enable = 1'b1;
        step();
    endtask

    task automatic test_grst_mid();
        logic ov;
        clear_pat();
        pat[2] = 4'b0100;
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            req = pat[c];
            step();
        end
        req  = '0;
        grst = 1'b1;
        step();
        m_ptr = 0;
        got = {gamma_start, out_valid, overrun, win_none, win_idx, win_time};
        n_cmp++;
        if (got !== 10'd0 || gamma_count !== '0) begin
            n_bad++;
            $display("FAIL grst_mid: got %b cnt=%0d want 0", got, gamma_count);
        end
        grst   = 1'b0;
        enable = 1'b0;
        step();
        n_cmp++;
        if ({gamma_start, gamma_count, out_valid} !== 6'd0) begin
            n_bad++;
            $display("FAIL grst_idle: got %b want 0",
                     {gamma_start, gamma_count, out_valid});
        end
        enable = 1'b1;
        step();
        clear_pat();
        run_gamma(0, -1, ov);
        model_gamma();
        got   = {gamma_start, out_valid, overrun, win_none, win_idx, win_time};
        exp_v = {3'b110, e_none, e_idx, e_time};
        n_cmp++;
        if (got !== exp_v) begin
            n_bad++;
            $display("FAIL grst_discard: got %b want %b", got, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_random();
        test_backpressure();
        test_control();
        test_grst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
